// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bus between the EX/MEM register (master side) and the MEM-stage data memory
// controller (slave side).
//
// Handshake: a request (MemRead | MemWrite) is taken only while the controller
// is IDLE. mem_stall acts as the inverse of "ready": while it is high the
// upstream stages must hold. In the DONE cycle mem_stall is low, RD is valid
// and MEM/WB captures it on the closing edge. Request inputs still present in
// DONE are ignored, so the same instruction is never executed twice.
//
// Signals:
//   MemRead, MemWrite  master -> slave  load / store request
//   alu_out[31:0]      master -> slave  byte address
//   wd[31:0]           master -> slave  store data
//   RD[31:0]           slave  -> master registered load data
//   mem_stall          slave  -> master freeze upstream stages
//   mem_busy           slave  -> master controller not IDLE
//   dbg_state[1:0]     slave  -> master FSM state (debug)
//   misalign           slave  -> master misaligned access trap
//                                       (only with MEM_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] alu_out;
   logic [31:0] wd;
   logic [31:0] RD;
   logic        mem_stall;
   logic        mem_busy;
   logic [1:0]  dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;

   modport master (
      output MemRead, MemWrite, alu_out, wd,
      input  RD, mem_stall, mem_busy, dbg_state, misalign
   );
   modport slave (
      input  MemRead, MemWrite, alu_out, wd,
      output RD, mem_stall, mem_busy, dbg_state, misalign
   );
`else
   modport master (
      output MemRead, MemWrite, alu_out, wd,
      input  RD, mem_stall, mem_busy, dbg_state
   );
   modport slave (
      input  MemRead, MemWrite, alu_out, wd,
      output RD, mem_stall, mem_busy, dbg_state
   );
`endif
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data memory controller. Holds a word-addressed data memory with a
// fixed access latency and sequences each lw/sw through IDLE -> BUSY -> DONE,
// stalling the upstream pipeline while an access is in flight.
//
// Ports:
//   clk   pipeline clock, rising edge
//   rst   synchronous, active-high reset (memory contents are kept)
//   bus   mem_access_unit_if.slave: MemRead, MemWrite, alu_out, wd in;
//         RD, mem_stall, mem_busy, dbg_state (and misalign) out
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two)
//   ADDR_W   log2(DEPTH); word index = alu_out[ADDR_W+1:2]
//   LATENCY  BUSY cycles per access, 1..15
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   When defined, a request with alu_out[1:0] != 0 skips the array, goes
//   straight IDLE -> DONE and raises misalign for the DONE cycle.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_idx;
   logic [31:0]       r_wd;
   logic              r_store;
   logic [31:0]       r_rd;
   logic [31:0]       r_mem [DEPTH];

   logic              w_req;
   logic              w_trap;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_idx;
   logic              w_unused_addr;

   assign w_req = bus.MemRead | bus.MemWrite;
   assign w_idx = bus.alu_out[ADDR_W+1:2];

   // Address bits outside the word index only matter for the trap feature.
   assign w_unused_addr = ^{bus.alu_out[31:ADDR_W+2], bus.alu_out[1:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap = (bus.alu_out[1:0] != 2'b00);
`else
   assign w_trap = 1'b0;
`endif

   // Array write happens on the last BUSY edge; a reset on that edge aborts it.
   assign w_mem_we = !rst && (r_state == S_BUSY) && (r_cnt == 4'd0) && r_store;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_wd    <= 32'd0;
         r_store <= 1'b0;
         r_rd    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_trap) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                     r_cnt   <= 4'(LATENCY - 1);
                     r_idx   <= w_idx;
                     r_wd    <= bus.wd;
                     // Both strobes high is treated as a store.
                     r_store <= bus.MemWrite;
                  end
               end
            end
            S_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (!r_store) r_rd <= r_mem[r_idx];
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Request inputs are still those of the finished instruction.
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[r_idx] <= r_wd;
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misalign;

   // Set on the IDLE -> DONE trap edge, so it is high exactly in DONE.
   always_ff @(posedge clk) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= (r_state == S_IDLE) && w_req && w_trap;
   end

   assign bus.misalign = r_misalign;
`endif

   assign bus.RD        = r_rd;
   assign bus.mem_stall = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
   assign bus.mem_busy  = (r_state != S_IDLE);
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int DEPTH   = 256;
   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   mem_access_unit_if bus ();

   mem_access_unit #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] rd_model;
   logic [31:0] exp_q [$];
   int          n_checks;
   int          n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   // ---------------- driver tasks ----------------
   // Called at #1 after a rising edge with the controller idle; returns at #1
   // after the DONE edge, so another access can start back-to-back.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit scramble);
      bit          trap;
      bit          done_seen;
      int          stalls;
      int          exp_stalls;
      logic [31:0] exp_rd;
      trap = TRAP_EN && (addr[1:0] != 2'b00);
      if (!trap) begin
         if (wr)      ref_mem[word_of(addr)] = data;
         else if (rd) rd_model = ref_mem[word_of(addr)];
      end
      exp_q.push_back(rd_model);
      exp_stalls = trap ? 1 : LATENCY + 1;

      bus.MemRead  = rd;
      bus.MemWrite = wr;
      bus.alu_out  = addr;
      bus.wd       = data;
      stalls       = 0;
      done_seen    = 1'b0;
      for (int c = 0; c < LATENCY + 10 && !done_seen; c++) begin
         @(negedge clk);
         if (bus.mem_stall) begin
            stalls++;
            @(posedge clk);
            #1;
            // Upstream operands wander while held; the latched copy must win.
            if (scramble) begin
               bus.alu_out = $urandom;
               bus.wd      = $urandom;
            end
         end else begin
            done_seen = 1'b1;
         end
      end
      exp_rd = exp_q.pop_front();
      if (!done_seen) begin
         check("done_timeout", 32'(stalls), 32'(exp_stalls));
      end else begin
         check("stall_cycles", 32'(stalls), 32'(exp_stalls));
         check("busy_in_done", 32'(bus.mem_busy), 32'd1);
         check("rd_in_done", bus.RD, exp_rd);
`ifdef MEM_MISALIGN_TRAP_EN
         check("misalign_in_done", 32'(bus.misalign), 32'(trap));
`endif
      end
      // Request still asserted through DONE: must not start a second access.
      @(posedge clk);
      #1;
      check("no_retrigger", 32'(bus.mem_busy), 32'd0);
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_stall", 32'(bus.mem_stall), 32'd0);
         check("idle_busy", 32'(bus.mem_busy), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   // Store aborted by reset asserted during its second BUSY cycle.
   task automatic abort_store(input logic [31:0] addr, input logic [31:0] data);
      bus.MemWrite = 1'b1;
      bus.alu_out  = addr;
      bus.wd       = data;
      @(posedge clk);
      #1;
      bus.MemWrite = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy_before", 32'(bus.mem_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_model = 32'd0;
      check("abort_busy", 32'(bus.mem_busy), 32'd0);
      check("abort_stall", 32'(bus.mem_stall), 32'd0);
      check("abort_rd", bus.RD, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      n_checks     = 0;
      n_fail       = 0;
      rd_model     = 32'd0;
      rst          = 1'b1;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.alu_out  = 32'd0;
      bus.wd       = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd", bus.RD, 32'd0);
      check("reset_stall", 32'(bus.mem_stall), 32'd0);
      check("reset_busy", 32'(bus.mem_busy), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
      check("reset_misalign", 32'(bus.misalign), 32'd0);
`endif
      rst = 1'b0;
      idle_cycles(2);

      // Known contents everywhere so later loads have a defined answer.
      for (int i = 0; i < DEPTH; i++) do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

      // Directed cases.
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      check("lw_deadbeef", bus.RD, 32'hDEADBEEF);

      do_access(1'b0, 1'b1, 32'h0, 32'h11, 1'b0);
      do_access(1'b0, 1'b1, 32'h4, 32'h22, 1'b0);
      do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("b2b_first", bus.RD, 32'h11);
      do_access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      check("b2b_second", bus.RD, 32'h22);

      do_access(1'b0, 1'b1, 32'h400, 32'h55, 1'b0);
      do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("wrap_load", bus.RD, 32'h55);

      abort_store(32'h8, 32'h99);
      do_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      check("abort_no_write", 32'(bus.RD == 32'h99), 32'd0);

      do_access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      do_access(1'b1, 1'b1, 32'hC, 32'h7, 1'b0);
      check("dual_rd_kept", bus.RD, 32'h22);
      do_access(1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
      check("dual_stored", bus.RD, 32'h7);

      do_access(1'b1, 1'b0, 32'h6, 32'h0, 1'b0);
      do_access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      check("word1_intact", bus.RD, 32'h22);
      idle_cycles(1);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         op = 2'($urandom_range(1, 3));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         do_access(op[0], op[1], a, $urandom, 1'b1);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
